usb_hs_bus_arbiter: RTL and testbench

Two-requester arbiter/sequencer for the usbHostSlave 8-bit register bus (address_i/data_i/data_o/writeEn/strobe_i/ack_o). Port A is the CPU path (Avalon-side glue); port B is a FIFO-drain/DMA engine. Transactions are granted round-robin, optionally locked for atomic read-modify-write sequences, and run one at a time to the core. Sits between the bus wrapper glue and the usbHostSlave instance.

---
 rtl/usb_hs_bus_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_usb_hs_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_hs_bus_arbiter.sv
// ---------------------------------------------------------------------------
// usb_hs_bus_arbiter
//
// Two-requester arbiter/sequencer for the usbHostSlave 8-bit register bus.
// Port A is the CPU path and port B is the FIFO-drain/DMA engine. Requests are
// granted round-robin, can be locked by the current owner for atomic
// read-modify-write sequences, and are run one at a time against the core.
//
// Optional feature macro: USB_ARB_TIMEOUT_EN
//   defined   -> a BUS cycle counter forces termination (err=1, rdata=8'hFF)
//                after TIMEOUT_CYCLES cycles without ack_i.
//   undefined -> BUS waits for ack_i indefinitely; a_err/b_err stay 0.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   a_req/a_lock/a_addr/a_wdata/a_we  port A request side (held until a_ack)
//   a_rdata/a_ack/a_err             port A completion (one-cycle a_ack)
//   b_*                             same as port A, for port B
//   address_o/data_o/writeEn_o/strobe_o  to the core register bus
//   data_i/ack_i                    from the core register bus
//   owner                           current/last owner (0=A, 1=B)
// ---------------------------------------------------------------------------
module usb_hs_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMEOUT_W      = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       a_req,
    input  logic       a_lock,
    input  logic [7:0] a_addr,
    input  logic [7:0] a_wdata,
    input  logic       a_we,
    output logic [7:0] a_rdata,
    output logic       a_ack,
    output logic       a_err,
    input  logic       b_req,
    input  logic       b_lock,
    input  logic [7:0] b_addr,
    input  logic [7:0] b_wdata,
    input  logic       b_we,
    output logic [7:0] b_rdata,
    output logic       b_ack,
    output logic       b_err,
    output logic [7:0] address_o,
    output logic [7:0] data_o,
    output logic       writeEn_o,
    output logic       strobe_o,
    input  logic [7:0] data_i,
    input  logic       ack_i,
    output logic       owner
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t state, stateNext;
    logic   lockHold;
    logic   ownerReq, ownerLock, ownerErr, effLock;
    logic   doGrant, grantB, busEnd, busTimeout;

`ifdef USB_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] toCount;

    // Counter is held at zero outside BUS, so it starts from zero on every entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            toCount <= '0;
        end else if (state != BUS) begin
            toCount <= '0;
        end else if (!ack_i) begin
            toCount <= toCount + TIMEOUT_W'(1);
        end
    end
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = ^(TIMEOUT_W'(TIMEOUT_CYCLES));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        ownerReq   = owner ? b_req  : a_req;
        ownerLock  = owner ? b_lock : a_lock;
        ownerErr   = owner ? b_err  : a_err;
        // A lock only survives while the owner keeps its lock line high.
        effLock    = lockHold & ownerLock;
        stateNext  = state;
        doGrant    = 1'b0;
        grantB     = owner;
        busEnd     = 1'b0;
        busTimeout = 1'b0;
        case (state)
            IDLE: begin
                if (effLock) begin
                    if (ownerReq) begin
                        doGrant = 1'b1;
                        grantB  = owner;
                    end
                end else if (a_req && b_req) begin
                    doGrant = 1'b1;
                    grantB  = ~owner;
                end else if (a_req) begin
                    doGrant = 1'b1;
                    grantB  = 1'b0;
                end else if (b_req) begin
                    doGrant = 1'b1;
                    grantB  = 1'b1;
                end
                if (doGrant) begin
                    stateNext = BUS;
                end
            end
            BUS: begin
                // ack_i in the expiry cycle still counts as a normal completion.
                if (ack_i) begin
                    busEnd    = 1'b1;
                    stateNext = DONE;
                end
`ifdef USB_ARB_TIMEOUT_EN
                else if (toCount == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                    busTimeout = 1'b1;
                    stateNext  = DONE;
                end
`endif
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lockHold  <= 1'b0;
            owner     <= 1'b1;
            address_o <= 8'h00;
            data_o    <= 8'h00;
            writeEn_o <= 1'b0;
            strobe_o  <= 1'b0;
            a_rdata   <= 8'h00;
            b_rdata   <= 8'h00;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_err     <= 1'b0;
            b_err     <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            a_err <= 1'b0;
            b_err <= 1'b0;
            case (state)
                IDLE: begin
                    lockHold <= effLock;
                    if (doGrant) begin
                        owner     <= grantB;
                        address_o <= grantB ? b_addr  : a_addr;
                        data_o    <= grantB ? b_wdata : a_wdata;
                        writeEn_o <= grantB ? b_we    : a_we;
                        strobe_o  <= 1'b1;
                    end
                end
                BUS: begin
                    if (busEnd || busTimeout) begin
                        strobe_o  <= 1'b0;
                        writeEn_o <= 1'b0;
                        if (owner) begin
                            b_ack   <= 1'b1;
                            b_err   <= busTimeout;
                            b_rdata <= busTimeout ? 8'hFF : data_i;
                        end else begin
                            a_ack   <= 1'b1;
                            a_err   <= busTimeout;
                            a_rdata <= busTimeout ? 8'hFF : data_i;
                        end
                    end
                end
                DONE: begin
                    // A timed-out owner loses its lock.
                    lockHold <= ownerLock & ~ownerErr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_hs_bus_arbiter.sv
module tb_usb_hs_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       a_req = 1'b0, a_lock = 1'b0, a_we = 1'b0;
    logic [7:0] a_addr = 8'h00, a_wdata = 8'h00;
    logic       b_req = 1'b0, b_lock = 1'b0, b_we = 1'b0;
    logic [7:0] b_addr = 8'h00, b_wdata = 8'h00;
    logic [7:0] a_rdata, b_rdata, address_o, data_o;
    logic       a_ack, a_err, b_ack, b_err, writeEn_o, strobe_o, owner;
    logic [7:0] data_i = 8'h00;
    logic       ack_i = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit       isB;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit       we;
        logic [7:0] rdata;
        bit       err;
    } exp_t;
    exp_t sb[$];

    logic [7:0] mdlA = 8'h00, mdlB = 8'h00;

    // core model controls/observations
    int         ackDelay = 1;
    bit         noAck = 1'b0;
    int         strobeCnt = 0;
    int         lastStrobeLen = 0;
    logic [7:0] seenAddr = 8'h00, seenData = 8'h00;
    logic       seenWe = 1'b0;

    usb_hs_bus_arbiter #(.TIMEOUT_CYCLES(64), .TIMEOUT_W(7)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we),
        .a_rdata(a_rdata), .a_ack(a_ack), .a_err(a_err),
        .b_req(b_req), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata), .b_we(b_we),
        .b_rdata(b_rdata), .b_ack(b_ack), .b_err(b_err),
        .address_o(address_o), .data_o(data_o), .writeEn_o(writeEn_o), .strobe_o(strobe_o),
        .data_i(data_i), .ack_i(ack_i), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Core register-bus model: returns addr^8'hE3 after ackDelay strobe cycles.
    always @(negedge clk) begin
        if (strobe_o) begin
            strobeCnt = strobeCnt + 1;
            seenAddr = address_o;
            seenData = data_o;
            seenWe   = writeEn_o;
            if (!noAck && strobeCnt >= ackDelay) begin
                ack_i  = 1'b1;
                data_i = address_o ^ 8'hE3;
            end else begin
                ack_i = 1'b0;
            end
        end else begin
            if (strobeCnt != 0) lastStrobeLen = strobeCnt;
            strobeCnt = 0;
            ack_i = 1'b0;
            data_i = 8'h00;
        end
    end

    // Monitor: pop and compare on every completion pulse.
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            if (reset_n && (a_ack || b_ack)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {30'd0, b_ack, a_ack}, 32'd0);
                end else begin
                    it = sb.pop_front();
                    chk("ack_port", {30'd0, b_ack, a_ack}, it.isB ? 32'd2 : 32'd1);
                    chk("owner", owner, it.isB);
                    chk("bus_addr", seenAddr, it.addr);
                    chk("bus_wdata", seenData, it.wdata);
                    chk("bus_we", seenWe, it.we);
                    if (it.isB) begin
                        chk("b_rdata", b_rdata, it.rdata);
                        chk("b_err", b_err, it.err);
                        chk("a_rdata_hold", a_rdata, mdlA);
                        mdlB = it.rdata;
                    end else begin
                        chk("a_rdata", a_rdata, it.rdata);
                        chk("a_err", a_err, it.err);
                        chk("b_rdata_hold", b_rdata, mdlB);
                        mdlA = it.rdata;
                    end
                end
            end
        end
    end

    function automatic exp_t mk(bit isB, logic [7:0] addr, logic [7:0] wdata, bit we,
                                logic [7:0] rdata, bit err);
        exp_t e;
        e.isB = isB; e.addr = addr; e.wdata = wdata; e.we = we; e.rdata = rdata; e.err = err;
        return e;
    endfunction

    task automatic portA(input logic [7:0] addr, input logic [7:0] wdata, input logic we,
                         input logic lockDuring, input logic lockAfter);
        int n;
        @(negedge clk);
        a_addr = addr; a_wdata = wdata; a_we = we; a_lock = lockDuring; a_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_ack && n < 300);
        if (!a_ack) chk("a_ack_timeout", 32'd0, 32'd1);
        a_req = 1'b0;
        a_lock = lockAfter;
    endtask

    task automatic portB(input logic [7:0] addr, input logic [7:0] wdata, input logic we,
                         input logic lockDuring, input logic lockAfter);
        int n;
        @(negedge clk);
        b_addr = addr; b_wdata = wdata; b_we = we; b_lock = lockDuring; b_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_ack && n < 300);
        if (!b_ack) chk("b_ack_timeout", 32'd0, 32'd1);
        b_req = 1'b0;
        b_lock = lockAfter;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
        mdlA = 8'h00; mdlB = 8'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        doReset();
        // reset state
        chk("rst_strobe", strobe_o, 1'b0);
        chk("rst_we", writeEn_o, 1'b0);
        chk("rst_acks", {a_ack, b_ack, a_err, b_err}, 4'h0);
        chk("rst_owner", owner, 1'b1);
        chk("rst_addr", address_o, 8'h00);
        chk("rst_data", data_o, 8'h00);
        chk("rst_rdata", {a_rdata, b_rdata}, 16'h0000);

        // single A write, core acks on the first strobe cycle
        ackDelay = 1;
        sb.push_back(mk(1'b0, 8'h10, 8'h5A, 1'b1, 8'hF3, 1'b0));
        portA(8'h10, 8'h5A, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("single_strobe_len", lastStrobeLen, 1);
        chk("single_owner", owner, 1'b0);

        // round-robin: after reset the first tie goes to A, then alternates
        doReset();
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk(1'b0, 8'h30 + 8'(i), 8'hA0 + 8'(i), 1'b0, (8'h30 + 8'(i)) ^ 8'hE3, 1'b0));
            sb.push_back(mk(1'b1, 8'h40 + 8'(i), 8'hB0 + 8'(i), 1'b1, (8'h40 + 8'(i)) ^ 8'hE3, 1'b0));
            fork
                portA(8'h30 + 8'(i), 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
                portB(8'h40 + 8'(i), 8'hB0 + 8'(i), 1'b1, 1'b0, 1'b0);
            join
        end

        // B read with a slow core
        ackDelay = 3;
        sb.push_back(mk(1'b1, 8'h20, 8'h00, 1'b0, 8'hC3, 1'b0));
        portB(8'h20, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("slow_strobe_len", lastStrobeLen, 3);
        ackDelay = 1;

        // locked A sequence while B waits; lock released while idle
        sb.push_back(mk(1'b0, 8'h50, 8'h01, 1'b1, 8'hB3, 1'b0));
        sb.push_back(mk(1'b0, 8'h51, 8'h02, 1'b1, 8'hB2, 1'b0));
        sb.push_back(mk(1'b0, 8'h52, 8'h03, 1'b1, 8'hB1, 1'b0));
        sb.push_back(mk(1'b1, 8'h60, 8'h04, 1'b1, 8'h83, 1'b0));
        fork
            begin
                portA(8'h50, 8'h01, 1'b1, 1'b1, 1'b1);
                portA(8'h51, 8'h02, 1'b1, 1'b1, 1'b1);
                portA(8'h52, 8'h03, 1'b1, 1'b1, 1'b1);
                repeat (3) @(negedge clk);
                chk("lock_b_waiting", {strobe_o, b_req}, 2'b01);
                a_lock = 1'b0;
            end
            begin
                @(negedge clk);
                portB(8'h60, 8'h04, 1'b1, 1'b0, 1'b0);
            end
        join

`ifdef USB_ARB_TIMEOUT_EN
        // core never answers: forced termination after 64 strobe cycles
        noAck = 1'b1;
        sb.push_back(mk(1'b0, 8'h70, 8'h00, 1'b0, 8'hFF, 1'b1));
        portA(8'h70, 8'h00, 1'b0, 1'b0, 1'b0);
        noAck = 1'b0;
        @(negedge clk);
        chk("timeout_strobe_len", lastStrobeLen, 64);
        sb.push_back(mk(1'b0, 8'h71, 8'h00, 1'b0, 8'h92, 1'b0));
        portA(8'h71, 8'h00, 1'b0, 1'b0, 1'b0);
`endif

        // reset during BUS aborts without an ack pulse
        ackDelay = 10;
        @(negedge clk);
        a_addr = 8'h80; a_wdata = 8'h00; a_we = 1'b0; a_req = 1'b1;
        n = 0;
        while (!strobe_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_strobe_seen", strobe_o, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        mdlA = 8'h00; mdlB = 8'h00;
        #1;
        chk("abort_strobe", strobe_o, 1'b0);
        chk("abort_owner", owner, 1'b1);
        chk("abort_ack", {a_ack, b_ack}, 2'b00);
        a_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ackDelay = 1;
        repeat (15) @(negedge clk);
        sb.push_back(mk(1'b0, 8'h81, 8'h33, 1'b1, 8'h62, 1'b0));
        portA(8'h81, 8'h33, 1'b1, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
